sig_host_port: RTL

// Synthesizable memory-mapped host port for the RV32I core's signature/halt protocol.

---
 rtl/sig_host_port_if.sv | 23 ++
 rtl/sig_host_port.sv | 126 ++++++++++++
 2 files changed

// File: rtl/sig_host_port_if.sv
// Bus bundle for the signature/halt host port: core write snoop plus the UART byte stream.
interface sig_host_port_if;
   logic        dmem_wr_en;
   logic [31:0] dmem_wr_addr;
   logic [31:0] dmem_wr_data;
   logic        mmio_hit;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        halted;
   logic        overflow;
   logic [7:0]  drop_cnt;

   modport master (
      output dmem_wr_en, dmem_wr_addr, dmem_wr_data, tx_ready,
      input  mmio_hit, tx_data, tx_valid, halted, overflow, drop_cnt
   );

   modport slave (
      input  dmem_wr_en, dmem_wr_addr, dmem_wr_data, tx_ready,
      output mmio_hit, tx_data, tx_valid, halted, overflow, drop_cnt
   );
endinterface

// File: rtl/sig_host_port.sv
// Signature/halt host port: claims SIG/HALT writes, queues signature words and streams each one
// as an 8-digit lowercase hex line on a byte interface; flags halt once everything has drained.
module sig_host_port #(
   parameter logic [31:0] SIG_ADDR   = 32'hF000_0004,
   parameter logic [31:0] HALT_ADDR  = 32'hF000_0000,
   parameter logic [31:0] HALT_MAGIC = 32'hCAFE_CAFE,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input logic            sysclk,
   input logic            nrst_in,
   sig_host_port_if.slave bus
);
   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StHex, StNl} state_e;

   state_e          state_q, state_d;
   logic [31:0]     fifo_q [FIFO_DEPTH];
   logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
   logic [PtrW:0]   count_q;
   logic [31:0]     word_q, word_d;
   logic [2:0]      nib_q, nib_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_valid_q, tx_valid_d;
   logic            halt_req_q, halted_q, overflow_q;
   logic [7:0]      drop_cnt_q;
   logic            fifo_empty, fifo_full, push_req, push, pop, drop, halt_set, accept;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
   endfunction

   assign bus.mmio_hit = bus.dmem_wr_en &&
                         (bus.dmem_wr_addr == SIG_ADDR || bus.dmem_wr_addr == HALT_ADDR);
   assign push_req   = bus.dmem_wr_en && bus.dmem_wr_addr == SIG_ADDR && !halt_req_q;
   assign halt_set   = bus.dmem_wr_en && bus.dmem_wr_addr == HALT_ADDR &&
                       bus.dmem_wr_data == HALT_MAGIC;
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == (PtrW + 1)'(FIFO_DEPTH));
   assign pop        = (state_q == StIdle) && !fifo_empty;
   // A full FIFO still takes the word when the head leaves on the same edge.
   assign push       = push_req && (!fifo_full || pop);
   assign drop       = push_req && fifo_full && !pop;
   assign accept     = tx_valid_q && bus.tx_ready;

   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      nib_d      = nib_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      unique case (state_q)
         StIdle: begin
            if (pop) begin
               word_d     = fifo_q[rd_ptr_q];
               nib_d      = 3'd7;
               tx_valid_d = 1'b1;
               tx_data_d  = hex_ascii(fifo_q[rd_ptr_q][31:28]);
               state_d    = StHex;
            end
         end
         StHex: begin
            if (accept) begin
               if (nib_q == 3'd0) begin
                  tx_data_d = 8'h0A;
                  state_d   = StNl;
               end else begin
                  nib_d     = nib_q - 3'd1;
                  tx_data_d = hex_ascii(word_q[{nib_d, 2'b00} +: 4]);
               end
            end
         end
         StNl: begin
            if (accept) begin
               tx_valid_d = 1'b0;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge sysclk) begin
      if (push) fifo_q[wr_ptr_q] <= bus.dmem_wr_data;
   end

   always_ff @(posedge sysclk) begin
      if (!nrst_in) begin
         state_q    <= StIdle;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         word_q     <= '0;
         nib_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         halt_req_q <= 1'b0;
         halted_q   <= 1'b0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         nib_q      <= nib_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
         if (halt_set) halt_req_q <= 1'b1;
         if (halt_req_q && fifo_empty && state_q == StIdle) halted_q <= 1'b1;
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
         end
      end
   end

   assign bus.tx_data  = tx_data_q;
   assign bus.tx_valid = tx_valid_q;
   assign bus.halted   = halted_q;
   assign bus.overflow = overflow_q;
   assign bus.drop_cnt = drop_cnt_q;
endmodule
